// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control scheduler for the five-stage CPU.
//
// Each cycle this block decides, from the instruction in MEM and the hazard and
// bus signals, which pipeline registers hold and which are cleared. It also
// sequences the machine modes RUN, EXC (inside a handler) and HALT. The saved
// return PC, the saved cause and the HALT resume PC are kept here.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous, active-high reset
//   if_busy       in   fetch bus not ready
//   mem_busy      in   data bus not ready
//   ld_hazard     in   load-use hazard from the decoder
//   br_taken      in   ID-stage branch redirect
//   mem_en        in   MEM-stage instruction valid
//   mem_pc        in   MEM-stage PC (word address)
//   mem_ctrl_op   in   0 NOP, 1 EXRT, 2 HALT, 3 NOP
//   mem_exp_code  in   MEM-stage exception code, 0 = none
//   irq           in   level interrupt request
//   int_en        in   global interrupt enable
//   if_stall .. mem_stall   out  hold the IF/ID .. MEM/WB register
//   if_flush .. mem_flush   out  clear the IF/ID .. MEM/WB register
//   new_pc        out  redirect target, 0 when there is no redirect
//   int_detect    out  interrupt accepted this cycle (single-cycle pulse)
//   epc           out  saved return PC
//   exc_code      out  saved cause
//   in_handler    out  machine is in EXC
//   halted        out  machine is in HALT
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int                ADDR_W   = 30,
    parameter int                EXP_W    = 3,
    parameter logic [ADDR_W-1:0] VEC_ADDR = 30'h100,
    parameter logic [EXP_W-1:0]  IRQ_CODE = 3'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    input  logic              br_taken,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [1:0]        mem_ctrl_op,
    input  logic [EXP_W-1:0]  mem_exp_code,
    input  logic              irq,
    input  logic              int_en,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              int_detect,
    output logic [ADDR_W-1:0] epc,
    output logic [EXP_W-1:0]  exc_code,
    output logic              in_handler,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EXC  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] OP_EXRT = 2'd1;
    localparam logic [1:0] OP_HALT = 2'd2;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   epc_q,      epc_d;
    logic [EXP_W-1:0]    exc_code_q, exc_code_d;
    logic [ADDR_W-1:0]   halt_pc_q,  halt_pc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            epc_q      <= '0;
            exc_code_q <= '0;
            halt_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
            halt_pc_q  <= halt_pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    logic              stall_all;
    logic              exc_evt;
    logic              exrt_evt;
    logic              halt_evt;
    logic              irq_req;
    logic [ADDR_W-1:0] mem_pc_inc;

    assign stall_all  = if_busy | mem_busy;
    assign exc_evt    = mem_en & (mem_exp_code != '0);
    assign exrt_evt   = mem_en & (mem_ctrl_op == OP_EXRT);
    assign halt_evt   = mem_en & (mem_ctrl_op == OP_HALT);
    assign irq_req    = irq & int_en;
    // Wraps modulo 2^ADDR_W by construction.
    assign mem_pc_inc = mem_pc + ADDR_W'(1);

    // -------------------------------------------------------------------------
    // Combinational control: stage stall/flush, redirect and next state.
    // Exactly one event is honoured per cycle, highest priority first.
    // -------------------------------------------------------------------------
    logic [3:0] stall_vec;   // {if, id, ex, mem}
    logic [3:0] flush_vec;   // {if, id, ex, mem}
    logic [ADDR_W-1:0] new_pc_c;
    logic              int_detect_c;

    always_comb begin
        stall_vec    = 4'b0000;
        flush_vec    = 4'b0000;
        new_pc_c     = '0;
        int_detect_c = 1'b0;
        state_d      = state_q;
        epc_d        = epc_q;
        exc_code_d   = exc_code_q;
        halt_pc_d    = halt_pc_q;

        if (reset) begin
            // Outputs stay at their zero defaults while reset is held; the
            // registers are being cleared asynchronously anyway.
        end else if (stall_all) begin
            // A bus wait freezes everything; pending events are simply
            // re-evaluated once the bus is ready again.
            stall_vec = 4'b1111;
        end else if (state_q == ST_HALT) begin
            stall_vec = 4'b1111;
            // Only an enabled interrupt wakes the core; mem_en is irrelevant
            // because the pipeline behind the HALT is empty.
            if (irq_req) begin
                flush_vec    = 4'b1111;
                new_pc_c     = VEC_ADDR;
                int_detect_c = 1'b1;
                epc_d        = halt_pc_q;
                exc_code_d   = IRQ_CODE;
                state_d      = ST_EXC;
            end
        end else begin
            // RUN or EXC
            if (exc_evt) begin
                // Nested exceptions inside the handler overwrite EPC.
                flush_vec  = 4'b1111;
                new_pc_c   = VEC_ADDR;
                epc_d      = mem_pc;
                exc_code_d = mem_exp_code;
                state_d    = ST_EXC;
            end else if (exrt_evt) begin
                flush_vec = 4'b1111;
                new_pc_c  = epc_q;
                state_d   = ST_RUN;
            end else if (irq_req && mem_en && (state_q == ST_RUN)) begin
                // The MEM instruction is squashed and re-executed on return,
                // so its own PC becomes the return address.
                flush_vec    = 4'b1111;
                new_pc_c     = VEC_ADDR;
                int_detect_c = 1'b1;
                epc_d        = mem_pc;
                exc_code_d   = IRQ_CODE;
                state_d      = ST_EXC;
            end else if (halt_evt) begin
                // MEM/WB is left alone so the HALT itself retires.
                flush_vec = 4'b1110;
                new_pc_c  = mem_pc_inc;
                halt_pc_d = mem_pc_inc;
                state_d   = ST_HALT;
            end else if (ld_hazard) begin
                // Hold IF and ID, insert a bubble into EX. Masks br_taken:
                // the branch is re-seen once the hazard resolves.
                stall_vec = 4'b1100;
                flush_vec = 4'b0100;
            end else if (br_taken) begin
                flush_vec = 4'b1000;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign if_stall   = stall_vec[3];
    assign id_stall   = stall_vec[2];
    assign ex_stall   = stall_vec[1];
    assign mem_stall  = stall_vec[0];
    assign if_flush   = flush_vec[3];
    assign id_flush   = flush_vec[2];
    assign ex_flush   = flush_vec[1];
    assign mem_flush  = flush_vec[0];
    assign new_pc     = new_pc_c;
    assign int_detect = int_detect_c;
    assign epc        = epc_q;
    assign exc_code   = exc_code_q;
    assign in_handler = (state_q == ST_EXC);
    assign halted     = (state_q == ST_HALT);

endmodule
